// File: rtl/frame_buffer_dp.sv
// frame_buffer_dp -- parametrised pixel frame store for the VGA path.
//
// One independent write port (valid/ready, host side) and one read port with
// a single cycle of latency (scan-out side); both work in the same cycle.
// A built-in clear engine sweeps every cell with a colour, after reset (with
// FILL_VALUE) and on clear_req (with clear_color). The write port is stalled
// (wr_ready=0) while a sweep runs; reads are serviced at all times.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   wr_valid/wr_ready          write handshake; commit when both are high
//   wr_x, wr_y, wr_data        write coordinate and pixel
//   rd_en, rd_x, rd_y          read request and coordinate
//   rd_data, rd_valid          read result, one cycle after rd_en
//   clear_req, clear_color     start a sweep with the given colour
//   busy                       sweep in progress
//   clear_done                 one-cycle pulse in the first idle cycle
//
// Build option: define FRAME_BUFFER_RDW_BYPASS_EN to forward same-cycle
// write data to a read of the same address. Undefined (default), such a read
// returns the old contents, which keeps the array block-RAM friendly.

module frame_buffer_dp #(
   parameter int                H_PIXELS   = 64,
   parameter int                V_PIXELS   = 48,
   parameter int                PIX_W      = 3,
   parameter logic [PIX_W-1:0]  FILL_VALUE = 3'b010,
   localparam int               X_W        = $clog2(H_PIXELS),
   localparam int               Y_W        = $clog2(V_PIXELS),
   localparam int               DEPTH      = H_PIXELS * V_PIXELS,
   localparam int               ADDR_W     = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             wr_valid,
   output logic             wr_ready,
   input  logic [X_W-1:0]   wr_x,
   input  logic [Y_W-1:0]   wr_y,
   input  logic [PIX_W-1:0] wr_data,
   input  logic             rd_en,
   input  logic [X_W-1:0]   rd_x,
   input  logic [Y_W-1:0]   rd_y,
   output logic [PIX_W-1:0] rd_data,
   output logic             rd_valid,
   input  logic             clear_req,
   input  logic [PIX_W-1:0] clear_color,
   output logic             busy,
   output logic             clear_done
);

   // One extra bit so limits equal to a power of two are representable.
   localparam logic [X_W:0]      H_LIM     = (X_W+1)'(H_PIXELS);
   localparam logic [Y_W:0]      V_LIM     = (Y_W+1)'(V_PIXELS);
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

   typedef enum logic {IDLE, CLEAR} state_t;

   state_t            state;
   logic [ADDR_W-1:0] sweep_addr;
   logic [PIX_W-1:0]  sweep_color;

   logic [PIX_W-1:0]  mem [DEPTH];

   function automatic logic in_range(input logic [X_W-1:0] x, input logic [Y_W-1:0] y);
      return ({1'b0, x} < H_LIM) && ({1'b0, y} < V_LIM);
   endfunction

   function automatic logic [ADDR_W-1:0] pix_addr(input logic [X_W-1:0] x, input logic [Y_W-1:0] y);
      return ADDR_W'(y) * ADDR_W'(H_PIXELS) + ADDR_W'(x);
   endfunction

   assign wr_ready = (state == IDLE);
   assign busy     = (state == CLEAR);

   // ---------------------------------------------------------------------
   // Single array write port: the sweep owns it in CLEAR, the host in IDLE.
   // Out-of-range host writes complete the handshake but never reach here.
   // ---------------------------------------------------------------------
   logic              mem_we;
   logic [ADDR_W-1:0] mem_waddr;
   logic [PIX_W-1:0]  mem_wdata;

   // NOTE: every signal driven here gets a default first, so no latch is inferred.
   always_comb begin
      mem_we    = 1'b0;
      mem_waddr = '0;
      mem_wdata = '0;
      if (state == CLEAR) begin
         mem_we    = 1'b1;
         mem_waddr = sweep_addr;
         mem_wdata = sweep_color;
      end else if (wr_valid && in_range(wr_x, wr_y)) begin
         mem_we    = 1'b1;
         mem_waddr = pix_addr(wr_x, wr_y);
         mem_wdata = wr_data;
      end
   end

   // NOTE: the array has no reset; the clear sweep initialises it instead.
   always_ff @(posedge clk) begin
      if (mem_we) mem[mem_waddr] <= mem_wdata;
   end

   // ---------------------------------------------------------------------
   // Read port: one cycle of latency, zero for out-of-range coordinates.
   // ---------------------------------------------------------------------
   logic              rd_ok;
   logic [ADDR_W-1:0] rd_addr;
   logic [PIX_W-1:0]  rd_word;

   assign rd_ok   = in_range(rd_x, rd_y);
   assign rd_addr = pix_addr(rd_x, rd_y);

   always_comb begin
      rd_word = '0;
      if (rd_ok) begin
         rd_word = mem[rd_addr];
`ifdef FRAME_BUFFER_RDW_BYPASS_EN
         // Forward the word being written this cycle to a read of the same cell.
         if (mem_we && (mem_waddr == rd_addr)) rd_word = mem_wdata;
`endif
      end
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_data  <= '0;
         rd_valid <= 1'b0;
      end else begin
         rd_valid <= rd_en;
         if (rd_en) rd_data <= rd_word;   // holds its last value otherwise
      end
   end

   // ---------------------------------------------------------------------
   // Clear engine. Reset lands in CLEAR so the frame is filled after reset.
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= CLEAR;
         sweep_addr  <= '0;
         sweep_color <= FILL_VALUE;
         clear_done  <= 1'b0;
      end else begin
         clear_done <= 1'b0;
         unique case (state)
            IDLE: begin
               if (clear_req) begin
                  sweep_color <= clear_color;
                  sweep_addr  <= '0;
                  state       <= CLEAR;
               end
            end
            CLEAR: begin
               // clear_req is deliberately ignored while sweeping.
               if (sweep_addr == LAST_ADDR) begin
                  sweep_addr <= '0;
                  state      <= IDLE;
                  clear_done <= 1'b1;
               end else begin
                  sweep_addr <= sweep_addr + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
